yuv_to_rgb_writer: RTL and testbench

YUV_TO_RGB_WRITER -- requirements
Module: yuv_to_rgb_writer

---
 rtl/yuv_to_rgb_writer_pkg.sv | 39 +++
 rtl/yuv_csc_core.sv | 57 +++++
 rtl/yuv_to_rgb_writer.sv | 169 ++++++++++++++++
 tb/tb_yuv_to_rgb_writer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/yuv_to_rgb_writer_pkg.sv
`default_nettype none
// ============================================================================
// yuv_to_rgb_writer_pkg: shared state encoding, colour-conversion constants
// and output clipping for the YUV-to-RGB SRAM writer.          Rev 1.0
// ============================================================================
package yuv_to_rgb_writer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // 16.16 fixed-point BT.601 coefficients
    localparam int C_Y  = 76284;
    localparam int C_RV = 104595;
    localparam int C_GU = 25624;
    localparam int C_GV = 53281;
    localparam int C_BU = 132251;

    localparam int Y_OFFSET  = 16;
    localparam int UV_OFFSET = 128;

    localparam logic [17:0] DEFAULT_BASE = 18'd146944;

    function automatic logic [7:0] clip8(input logic signed [31:0] acc);
        logic signed [31:0] s;
        s = acc >>> 16;
        if (s < 0)
            return 8'h00;
        else if (s > 255)
            return 8'hFF;
        else
            return s[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/yuv_csc_core.sv
`default_nettype none
// ============================================================================
// yuv_csc_core: fixed 3-cycle YUV->RGB converter (offset, multiply, sum/clip);
// never stalls.                                                 Rev 1.0
// ============================================================================
module yuv_csc_core
    import yuv_to_rgb_writer_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic [7:0] y_i,
    input  logic [7:0] u_i,
    input  logic [7:0] v_i,
    output logic       valid_o,
    output logic [7:0] r_o,
    output logic [7:0] g_o,
    output logic [7:0] b_o,
    output logic [2:0] stage_valid_o
);

    logic [2:0]         vld_q;
    logic signed [8:0]  y1_q, u1_q, v1_q;
    logic signed [31:0] ry2_q, rv2_q, gu2_q, gv2_q, bu2_q;
    logic [7:0]         r3_q, g3_q, b3_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            vld_q <= '0;
        else
            vld_q <= {vld_q[1:0], valid_i};
    end

    always_ff @(posedge clk_i) begin
        y1_q  <= 9'($signed({1'b0, y_i}) - Y_OFFSET);
        u1_q  <= 9'($signed({1'b0, u_i}) - UV_OFFSET);
        v1_q  <= 9'($signed({1'b0, v_i}) - UV_OFFSET);

        ry2_q <= C_Y  * $signed({{23{y1_q[8]}}, y1_q});
        rv2_q <= C_RV * $signed({{23{v1_q[8]}}, v1_q});
        gu2_q <= C_GU * $signed({{23{u1_q[8]}}, u1_q});
        gv2_q <= C_GV * $signed({{23{v1_q[8]}}, v1_q});
        bu2_q <= C_BU * $signed({{23{u1_q[8]}}, u1_q});

        r3_q  <= clip8(ry2_q + rv2_q);
        g3_q  <= clip8(ry2_q - gu2_q - gv2_q);
        b3_q  <= clip8(ry2_q + bu2_q);
    end

    assign valid_o       = vld_q[2];
    assign r_o           = r3_q;
    assign g_o           = g3_q;
    assign b_o           = b3_q;
    assign stage_valid_o = vld_q;

endmodule
`default_nettype wire

// File: rtl/yuv_to_rgb_writer.sv
`default_nettype none
// ============================================================================
// yuv_to_rgb_writer: converts a YUV pixel stream to RGB and packs the bytes
// two per 16-bit word into consecutive SRAM addresses.          Rev 1.0
// ============================================================================
module yuv_to_rgb_writer
    import yuv_to_rgb_writer_pkg::*;
#(
    parameter int CAPACITY = 12
) (
    input  logic        Clock_50,
    input  logic        Reset,
    input  logic        Start,
    input  logic [16:0] Pixel_count,
    input  logic [17:0] Base_address,
    input  logic        In_valid,
    output logic        In_ready,
    input  logic [7:0]  In_Y,
    input  logic [7:0]  In_U,
    input  logic [7:0]  In_V,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        Finish
);

    localparam int CW = $clog2(CAPACITY + 4);

    state_t      state_q, state_d;
    logic [16:0] count_q, count_d, accepted_q, accepted_d;
    logic [17:0] next_addr_q, next_addr_d, addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_n_q, we_n_d;
    logic [7:0]  buf_q [CAPACITY];
    logic [7:0]  buf_d [CAPACITY];
    logic [CW-1:0] cnt_q, cnt_d, avail;
    logic [7:0]  merged [CAPACITY + 3];

    logic        load_base, accept, emit2, emit1, ready;
    logic        csc_valid;
    logic [7:0]  csc_r, csc_g, csc_b;
    logic [2:0]  stage_vld;
    logic [1:0]  inflight;
    int          need;

    yuv_csc_core u_csc (
        .clk_i         (Clock_50),
        .rst_i         (Reset),
        .valid_i       (accept),
        .y_i           (In_Y),
        .u_i           (In_U),
        .v_i           (In_V),
        .valid_o       (csc_valid),
        .r_o           (csc_r),
        .g_o           (csc_g),
        .b_o           (csc_b),
        .stage_valid_o (stage_vld)
    );

    // Credit: reserve buffer room for every pixel already in the pipeline
    assign inflight = 2'(stage_vld[0]) + 2'(stage_vld[1]) + 2'(stage_vld[2]);

    always_comb begin
        need  = int'(cnt_q) + 3 * int'(inflight) + 3;
        ready = !Reset && (state_q == S_RUN) && (accepted_q < count_q) && (need <= CAPACITY);
    end

    assign In_ready        = ready;
    assign accept          = In_valid && ready;
    assign Finish          = !Reset && (state_q == S_DONE);
    assign SRAM_address    = addr_q;
    assign SRAM_write_data = wdata_q;
    assign SRAM_we_n       = we_n_q;

    always_ff @(posedge Clock_50) begin
        if (Reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        accepted_d = accepted_q;
        load_base  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    count_d    = Pixel_count;
                    accepted_d = '0;
                    load_base  = 1'b1;
                    state_d    = (Pixel_count == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    accepted_d = accepted_q + 17'd1;
                    if (accepted_q + 17'd1 == count_q)
                        state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // The final word is on the bus in the cycle this becomes true
                if (stage_vld == 3'b000 && cnt_q == '0)
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (!Start)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Packer: buffered bytes followed by this cycle's R,G,B; pop two per word
    always_comb begin
        avail = csc_valid ? cnt_q + CW'(3) : cnt_q;
        for (int i = 0; i < CAPACITY + 3; i++) merged[i] = 8'h00;
        for (int i = 0; i < CAPACITY; i++) merged[i] = buf_q[i];
        if (csc_valid) begin
            merged[cnt_q]          = csc_r;
            merged[cnt_q + CW'(1)] = csc_g;
            merged[cnt_q + CW'(2)] = csc_b;
        end

        emit2 = (avail >= CW'(2));
        emit1 = (state_q == S_FLUSH) && (avail == CW'(1)) && (stage_vld[1:0] == 2'b00);

        for (int i = 0; i < CAPACITY; i++) buf_d[i] = emit2 ? merged[i + 2] : merged[i];
        cnt_d = emit2 ? avail - CW'(2) : (emit1 ? '0 : avail);

        we_n_d      = !(emit2 || emit1);
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        next_addr_d = next_addr_q;
        if (load_base) begin
            next_addr_d = Base_address;
        end else if (emit2 || emit1) begin
            addr_d      = next_addr_q;
            next_addr_d = next_addr_q + 18'd1;
            wdata_d     = emit2 ? {merged[0], merged[1]} : {merged[0], 8'h00};
        end
    end

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            count_q     <= '0;
            accepted_q  <= '0;
            next_addr_q <= DEFAULT_BASE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_n_q      <= 1'b1;
            cnt_q       <= '0;
            for (int i = 0; i < CAPACITY; i++) buf_q[i] <= 8'h00;
        end else begin
            count_q     <= count_d;
            accepted_q  <= accepted_d;
            next_addr_q <= next_addr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_n_q      <= we_n_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_yuv_to_rgb_writer.sv
`default_nettype none
// ============================================================================
// tb_yuv_to_rgb_writer: scoreboard bench for the YUV-to-RGB SRAM writer.
// Rev 1.0
// ============================================================================
module tb_yuv_to_rgb_writer;
    import yuv_to_rgb_writer_pkg::*;

    logic        Clock_50 = 1'b0;
    logic        Reset, Start, In_valid, In_ready, SRAM_we_n, Finish;
    logic [16:0] Pixel_count;
    logic [17:0] Base_address, SRAM_address;
    logic [7:0]  In_Y, In_U, In_V;
    logic [15:0] SRAM_write_data;

    typedef struct packed {
        logic [17:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  pend[$];
    wr_t         mon_e;
    logic [17:0] model_addr;
    int n_checks = 0, n_pass = 0, cyc = 0;
    int wr_count, first_wr_cyc, last_wr_cyc;
    int py[100], pu[100], pv[100];

    yuv_to_rgb_writer #(.CAPACITY(12)) dut (
        .Clock_50        (Clock_50),
        .Reset           (Reset),
        .Start           (Start),
        .Pixel_count     (Pixel_count),
        .Base_address    (Base_address),
        .In_valid        (In_valid),
        .In_ready        (In_ready),
        .In_Y            (In_Y),
        .In_U            (In_U),
        .In_V            (In_V),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n),
        .Finish          (Finish)
    );

    always #5 Clock_50 = ~Clock_50;
    always @(posedge Clock_50) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] ref_clip(input int acc);
        int s;
        s = acc >>> 16;
        if (s < 0) return 8'h00;
        if (s > 255) return 8'hFF;
        return 8'(s);
    endfunction

    function automatic void push_exp(input logic [17:0] a, input logic [15:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endfunction

    function automatic void model_push(input int y, input int u, input int v);
        int c, d, e;
        c = y - 16;
        d = u - 128;
        e = v - 128;
        pend.push_back(ref_clip(76284 * c + 104595 * e));
        pend.push_back(ref_clip(76284 * c - 25624 * d - 53281 * e));
        pend.push_back(ref_clip(76284 * c + 132251 * d));
        while (pend.size() >= 2) begin
            push_exp(model_addr, {pend[0], pend[1]});
            void'(pend.pop_front());
            void'(pend.pop_front());
            model_addr = model_addr + 18'd1;
        end
    endfunction

    always @(negedge Clock_50) begin
        if (!Reset && SRAM_we_n == 1'b0) begin
            if (wr_count == 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            wr_count++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write", 32'(SRAM_address), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("wr_addr", 32'(SRAM_address), 32'(mon_e.addr));
                check_eq("wr_data", 32'(SRAM_write_data), 32'(mon_e.data));
            end
        end
    end

    task automatic run_frame(input int n, input logic [17:0] base, input int gap_pct,
                             input int abort_at, input bit model_en);
        int acc, iter, overrun, first_acc, start_cyc, fin_cyc, k;
        acc = 0; iter = 0; overrun = 0; first_acc = -1;
        wr_count = 0; first_wr_cyc = -1; last_wr_cyc = -1;
        pend.delete();
        model_addr = base;
        @(posedge Clock_50); #1;
        Pixel_count  = 17'(n);
        Base_address = base;
        Start        = 1'b1;
        start_cyc    = cyc;
        while (acc < n && iter < 3000) begin
            if (abort_at > 0 && iter == abort_at) return;
            if (int'($urandom_range(99)) < gap_pct) begin
                In_valid = 1'b0;
                In_Y = 8'($urandom); In_U = 8'($urandom); In_V = 8'($urandom);
            end else begin
                In_valid = 1'b1;
                In_Y = 8'(py[acc]); In_U = 8'(pu[acc]); In_V = 8'(pv[acc]);
            end
            @(negedge Clock_50);
            if (In_valid && In_ready) begin
                if (first_acc < 0) first_acc = cyc;
                if (model_en) model_push(py[acc], pu[acc], pv[acc]);
                acc++;
            end
            @(posedge Clock_50); #1;
            iter++;
        end
        In_valid = 1'b0;
        check_eq("accept_count", acc, n);
        if (model_en && pend.size() == 1) push_exp(model_addr, {pend[0], 8'h00});
        k = 0;
        do begin
            @(negedge Clock_50);
            if (In_ready) overrun++;
            k++;
        end while (!Finish && k < 400);
        check_eq("finish_seen", 32'(Finish), 1);
        fin_cyc = cyc;
        check_eq("we_n_in_done", 32'(SRAM_we_n), 1);
        if (n > 0) begin
            check_eq("first_write_latency", first_wr_cyc - first_acc, 4);
            check_eq("finish_after_last_write", fin_cyc - last_wr_cyc, 1);
        end else begin
            check_eq("n0_finish_within_2", 32'(fin_cyc - start_cyc <= 2), 1);
        end
        check_eq("write_count", wr_count, (3 * n + 1) / 2);
        check_eq("scoreboard_empty", exp_q.size(), 0);
        check_eq("ready_overrun", overrun, 0);
        if (gap_pct == 0 && n > 0)
            check_eq("no_write_gaps", last_wr_cyc - first_wr_cyc + 1, wr_count);
        @(posedge Clock_50); #1;
        Start = 1'b0;
        @(negedge Clock_50);
        check_eq("finish_held", 32'(Finish), 1);
        @(negedge Clock_50);
        check_eq("finish_cleared", 32'(Finish), 0);
    endtask

    task automatic load_directed_pair();
        py[0] = 235; pu[0] = 128; pv[0] = 128;
        py[1] = 16;  pu[1] = 128; pv[1] = 255;
    endtask

    task automatic load_random();
        for (int i = 0; i < 100; i++) begin
            py[i] = int'($urandom_range(255));
            pu[i] = int'($urandom_range(255));
            pv[i] = int'($urandom_range(255));
        end
        py[3] = 255; pu[3] = 255; pv[3] = 0;
        py[4] = 0;   pu[4] = 0;   pv[4] = 255;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; Start = 1'b0; In_valid = 1'b0;
        In_Y = 8'h0; In_U = 8'h0; In_V = 8'h0;
        Pixel_count = '0; Base_address = '0;
        repeat (2) @(posedge Clock_50);
        @(negedge Clock_50);
        check_eq("rst_in_ready", 32'(In_ready), 0);
        check_eq("rst_finish", 32'(Finish), 0);
        check_eq("rst_we_n", 32'(SRAM_we_n), 1);
        check_eq("rst_addr", 32'(SRAM_address), 0);
        check_eq("rst_data", 32'(SRAM_write_data), 0);
        @(posedge Clock_50); #1;
        Reset = 1'b0;

        load_directed_pair();
        push_exp(18'd146944, 16'hFEFE);
        push_exp(18'd146945, 16'hFECA);
        push_exp(18'd146946, 16'h0000);
        run_frame(2, DEFAULT_BASE, 0, 0, 1'b0);

        py[0] = 255; pu[0] = 128; pv[0] = 128;
        push_exp(18'd1000, 16'hFFFF);
        push_exp(18'd1001, 16'hFF00);
        run_frame(1, 18'd1000, 0, 0, 1'b0);

        py[0] = 16; pu[0] = 128; pv[0] = 128;
        push_exp(18'd5, 16'h0000);
        push_exp(18'd6, 16'h0000);
        run_frame(1, 18'd5, 0, 0, 1'b0);

        run_frame(0, DEFAULT_BASE, 0, 0, 1'b1);

        load_random();
        run_frame(100, DEFAULT_BASE, 0, 0, 1'b1);

        load_directed_pair();
        push_exp(18'd262143, 16'hFEFE);
        push_exp(18'd0, 16'hFECA);
        push_exp(18'd1, 16'h0000);
        run_frame(2, 18'd262143, 0, 0, 1'b0);

        load_random();
        run_frame(37, 18'd200, 40, 0, 1'b1);

        load_random();
        run_frame(60, 18'd3000, 30, 25, 1'b1);
        Reset = 1'b1; Start = 1'b0; In_valid = 1'b0;
        @(negedge Clock_50);
        check_eq("ready_during_reset", 32'(In_ready), 0);
        check_eq("finish_during_reset", 32'(Finish), 0);
        @(posedge Clock_50); #1;
        Reset = 1'b0;
        exp_q.delete();
        pend.delete();
        wr_count = 0;
        @(negedge Clock_50);
        check_eq("post_reset_we_n", 32'(SRAM_we_n), 1);
        check_eq("post_reset_finish", 32'(Finish), 0);
        check_eq("post_reset_addr", 32'(SRAM_address), 0);
        check_eq("post_reset_state", 32'(dut.state_q), 32'(S_IDLE));
        repeat (10) @(negedge Clock_50);
        check_eq("no_writes_after_reset", wr_count, 0);

        load_directed_pair();
        push_exp(18'd146944, 16'hFEFE);
        push_exp(18'd146945, 16'hFECA);
        push_exp(18'd146946, 16'h0000);
        run_frame(2, DEFAULT_BASE, 0, 0, 1'b0);

        load_random();
        run_frame(100, 18'd262100, 25, 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
